zero_pad_writer: RTL and testbench
==================================

ZERO_PAD_WRITER -- requirements
Module: zero_pad_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one IEEE-754 single-precision word.
REQ-002 Parameter WIDTH, default 56: unpadded feature-map side length in pixels; the padded side length is WIDTH+2.
REQ-003 clk  input  1: the single clock; all state changes on the rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 start  input  1: single-cycle pulse that begins one padded frame; sampled only in IDLE.
REQ-006 data_in  input  DATA_WIDTH: unpadded pixel stream, row-major.
REQ-007 valid_in  input  1: data_in holds a valid pixel.
REQ-008 ready_in  output  1: combinational; the pixel is consumed on a clock edge when valid_in and ready_in are both high.
REQ-009 fifo_afull  input  1: almost-full flag from the downstream channel FIFO; asserted when at most one free entry remains.
REQ-010 wrreq  output  1: registered write strobe to the downstream channel FIFO.
REQ-011 data_out  output  DATA_WIDTH: registered write data, qualified by wrreq.
REQ-012 busy  output  1: high in state RUN.
REQ-013 frame_done  output  1: registered one-cycle pulse issued with the last write of a frame.

Function
REQ-014 The block SHALL use a state machine with states IDLE, RUN and DONE.
REQ-015 IDLE SHALL go to RUN on start; RUN SHALL go to DONE after the final write of a frame is issued; DONE SHALL go to IDLE after one cycle.
REQ-016 Counters row and col SHALL each span 0..WIDTH+1; both SHALL be 0 on entering RUN.
REQ-017 A position is border when row = 0, row = WIDTH+1, col = 0 or col = WIDTH+1; every other position is interior.
REQ-018 Emit condition at a border position: RUN && !fifo_afull.
REQ-019 Emit condition at an interior position: RUN && !fifo_afull && valid_in.
REQ-020 ready_in SHALL equal RUN && interior && !fifo_afull; in all other cases ready_in SHALL be 0.
REQ-021 On the edge following an emit, wrreq SHALL be 1, and data_out SHALL be 32'h0 for a border emit or the consumed data_in for an interior emit (1-cycle latency).
REQ-022 In any cycle with no emit, wrreq SHALL be 0 and data_out SHALL hold its previous value.
REQ-023 Positions SHALL advance only on an emit: col increments; at col = WIDTH+1, col wraps to 0 and row increments.
REQ-024 The emit at row = col = WIDTH+1 SHALL be the final write of the frame; frame_done SHALL be 1 on the same registered cycle as that write.
REQ-025 Each frame SHALL produce exactly (WIDTH+2)^2 writes and consume exactly WIDTH^2 pixels.
REQ-026 fifo_afull high SHALL freeze the counters, the state and ready_in = 0 for as long as it stays high, with no write lost or duplicated.
REQ-027 valid_in low at an interior position SHALL stall the block; border zeros SHALL never wait on valid_in.
REQ-028 start in RUN or DONE SHALL be ignored.
REQ-029 valid_in in IDLE or DONE SHALL NOT be consumed.
REQ-030 If fifo_afull and valid_in change in the same cycle, the emit decision SHALL use the values sampled at that edge.

Reset
REQ-031 Asserting rst low at any time, including mid-frame, SHALL force IDLE, row = col = 0, wrreq = 0, data_out = 0, busy = 0, frame_done = 0, ready_in = 0.
REQ-032 The frame in progress at reset SHALL be abandoned; no partial-frame completion is required.
REQ-033 After rst is released, the block SHALL wait for a new start.

Verification (WIDTH = 2, so 16 writes per frame)
REQ-034 Pixels A,B,C,D streamed continuously, fifo_afull = 0 -> data_out sequence 0,0,0,0, 0,A,B,0, 0,C,D,0, 0,0,0,0 over 16 consecutive wrreq cycles; frame_done on the 16th.
REQ-035 fifo_afull held high for 5 cycles after the 6th write -> wrreq = 0 and ready_in = 0 during the hold; the sequence then resumes with B, no loss or duplication.
REQ-036 valid_in low for 3 cycles before C -> writes 8 and 9 (0,0) proceed; the block waits at write 10 until C is presented.
REQ-037 rst low after the 7th write, then a new start -> outputs clear immediately; the next frame begins again with 4 zeros.
REQ-038 start pulsed during RUN, and valid_in high while IDLE -> no effect; ready_in = 0 while IDLE; exactly 16 writes for the frame.
REQ-039 Two back-to-back frames -> busy = 0 for at least 2 cycles between them; 32 writes total and two frame_done pulses.

Source files
------------

// File: rtl/zero_pad_writer.sv
// zero_pad_writer: wraps a row-major WIDTH x WIDTH pixel stream with a one-pixel
// ring of zeros and writes the (WIDTH+2) x (WIDTH+2) result into a downstream
// channel FIFO. Border zeros are generated locally and never wait on the input
// stream. Interior positions pass one input pixel each. Every write is throttled
// by the FIFO almost-full flag.
module zero_pad_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic                  fifo_afull,
    output logic                  wrreq,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  frame_done
);

    // Counter width must hold the largest padded index, WIDTH+1.
    localparam int            CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_POS = CW'(WIDTH + 1);
    localparam logic [CW-1:0] ZERO_POS = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_POS  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           row_q;
    logic [CW-1:0]           col_q;
    logic [CW-1:0]           row_d;
    logic [CW-1:0]           col_d;
    logic [DATA_WIDTH-1:0]   data_d;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    wrreq_q;
    logic                    busy_q;
    logic                    frame_done_q;

    logic                    run_s;
    logic                    border_s;
    logic                    col_wrap_s;
    logic                    emit_s;
    logic                    last_s;

    // Position classification, handshake and emit decision for the current cycle.
    always_comb begin
        run_s      = (state_q == RUN);
        border_s   = (row_q == ZERO_POS) || (row_q == LAST_POS) ||
                     (col_q == ZERO_POS) || (col_q == LAST_POS);
        col_wrap_s = (col_q == LAST_POS);
        // A pixel is only accepted when it can be written out on the same edge.
        ready_in   = run_s && !border_s && !fifo_afull;
        emit_s     = run_s && !fifo_afull && (border_s || valid_in);
        last_s     = emit_s && (row_q == LAST_POS) && col_wrap_s;
    end

    // Next scan position and next write word, used only when an emit happens.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        data_d = {DATA_WIDTH{1'b0}};
        if (col_wrap_s) begin
            col_d = ZERO_POS;
            row_d = row_q + ONE_POS;
        end else begin
            col_d = col_q + ONE_POS;
            row_d = row_q;
        end
        if (border_s) begin
            data_d = {DATA_WIDTH{1'b0}};
        end else begin
            data_d = data_in;
        end
    end

    // Frame-control FSM together with the scan counters and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            row_q        <= ZERO_POS;
            col_q        <= ZERO_POS;
            wrreq_q      <= 1'b0;
            data_out_q   <= {DATA_WIDTH{1'b0}};
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wrreq_q      <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        row_q   <= ZERO_POS;
                        col_q   <= ZERO_POS;
                    end
                end
                RUN: begin
                    if (emit_s) begin
                        wrreq_q    <= 1'b1;
                        data_out_q <= data_d;
                        row_q      <= row_d;
                        col_q      <= col_d;
                        if (last_s) begin
                            frame_done_q <= 1'b1;
                            state_q      <= DONE;
                            busy_q       <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wrreq      = wrreq_q;
    assign data_out   = data_out_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_zero_pad_writer.sv
// Directed bench for zero_pad_writer with WIDTH = 2 (4x4 padded frame, 16 writes).
// Inputs change on the falling edge; outputs are sampled on the falling edge,
// and the combinational ready_in is sampled 1 time unit after the inputs change.
module tb_zero_pad_writer;

    localparam int DW = 32;
    localparam int W  = 2;
    localparam int NW = (W + 2) * (W + 2);
    localparam int MAXW = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          ready_in;
    logic          fifo_afull;
    logic          wrreq;
    logic [DW-1:0] data_out;
    logic          busy;
    logic          frame_done;

    int            n_checks = 0;
    int            n_pass   = 0;

    logic [DW-1:0] pix  [0:3];
    logic [DW-1:0] got  [0:MAXW-1];
    logic          fdv  [0:MAXW-1];
    int            wcyc [0:MAXW-1];

    always #5 clk = ~clk;

    zero_pad_writer #(.DATA_WIDTH(DW), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .fifo_afull (fifo_afull),
        .wrreq      (wrreq),
        .data_out   (data_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Expected padded word i in row-major order of the 4x4 output.
    function automatic logic [DW-1:0] exp_word(input int i);
        int r;
        int c;
        r = i / (W + 2);
        c = i % (W + 2);
        if (r == 0 || r == W + 1 || c == 0 || c == W + 1) return 32'h0000_0000;
        return pix[(r - 1) * W + (c - 1)];
    endfunction

    task automatic idle_outputs_check(input string name);
        chk({name, "_wrreq"},      {31'd0, wrreq},      32'd0);
        chk({name, "_data_out"},   data_out,            32'd0);
        chk({name, "_busy"},       {31'd0, busy},       32'd0);
        chk({name, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({name, "_ready_in"},   {31'd0, ready_in},   32'd0);
    endtask

    // One frame: start pulse, then stream pixels with optional afull hold,
    // valid gap, mid-run start pulse, or a reset after rst_at writes.
    task automatic run_frame(input string name, input int afull_at, input int afull_len,
                             input int gap_pix, input int gap_len, input int start_mid,
                             input int rst_at, input int exp_span);
        int n, pidx, hold_left, gap_left, c;
        bit done, prev_af, hold_used, gap_used, gap, acc;
        n = 0; pidx = 0; hold_left = 0; gap_left = 0; c = 0;
        done = 1'b0; prev_af = 1'b0; hold_used = 1'b0; gap_used = 1'b0;
        chk({name, "_busy_pre0"}, {31'd0, busy}, 32'd0);
        start = 1'b0; valid_in = 1'b0; fifo_afull = 1'b0;
        @(negedge clk);
        chk({name, "_busy_pre1"}, {31'd0, busy}, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && c < 200) begin
            if (prev_af) chk({name, "_hold_wrreq"}, {31'd0, wrreq}, 32'd0);
            if (wrreq) begin
                if (n < MAXW) begin
                    got[n]  = data_out;
                    fdv[n]  = frame_done;
                    wcyc[n] = c;
                end
                n++;
                if (frame_done) done = 1'b1;
            end
            if (rst_at > 0 && n == rst_at) begin
                rst = 1'b0;
                #1;
                idle_outputs_check({name, "_async"});
                valid_in = 1'b0; fifo_afull = 1'b0;
                repeat (2) @(negedge clk);
                chk({name, "_held_wrreq"}, {31'd0, wrreq}, 32'd0);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                chk({name, "_wait_start_busy"}, {31'd0, busy}, 32'd0);
                return;
            end
            if (!done) begin
                fifo_afull = 1'b0;
                if (!hold_used && n == afull_at) begin
                    hold_used = 1'b1;
                    hold_left = afull_len;
                end
                if (hold_left > 0) begin
                    fifo_afull = 1'b1;
                    hold_left--;
                end
                if (!gap_used && pidx == gap_pix && gap_len > 0) begin
                    gap_used = 1'b1;
                    gap_left = gap_len;
                end
                gap = (gap_left > 0);
                if (gap) gap_left--;
                valid_in = (pidx < 4) && !gap;
                data_in  = (pidx < 4) ? pix[pidx] : 32'hDEAD_BEEF;
                start    = (c == start_mid);
                #1;
                if (fifo_afull) chk({name, "_hold_ready"}, {31'd0, ready_in}, 32'd0);
                acc     = ready_in && valid_in;
                prev_af = fifo_afull;
                @(negedge clk);
                if (acc) pidx++;
                c++;
            end
        end
        start = 1'b0; valid_in = 1'b0; fifo_afull = 1'b0;
        chk({name, "_finished"}, {31'd0, done}, 32'd1);
        chk({name, "_wr_count"}, n, NW);
        chk({name, "_px_used"}, pidx, 4);
        for (int i = 0; i < NW && i < n; i++) begin
            chk($sformatf("%s_word%0d", name, i), got[i], exp_word(i));
            chk($sformatf("%s_fd%0d", name, i), {31'd0, fdv[i]}, (i == NW - 1) ? 32'd1 : 32'd0);
        end
        if (exp_span >= 0 && n >= NW) chk({name, "_span"}, wcyc[NW-1] - wcyc[0], exp_span);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; valid_in = 1'b0; fifo_afull = 1'b0; data_in = 32'h0;
        pix[0] = 32'h3F80_0000; pix[1] = 32'h4000_0000;
        pix[2] = 32'h4040_0000; pix[3] = 32'h4080_0000;
        repeat (2) @(negedge clk);
        idle_outputs_check("reset");
        rst = 1'b1;
        @(negedge clk);
        idle_outputs_check("post_reset");

        // Continuous stream, no back-pressure.
        run_frame("basic", -1, 0, -1, 0, -1, 0, 15);

        // FIFO almost-full held 5 cycles after the 6th write.
        pix[0] = 32'h1111_1111; pix[1] = 32'h2222_2222;
        pix[2] = 32'h3333_3333; pix[3] = 32'h4444_4444;
        run_frame("afull", 6, 5, -1, 0, -1, 0, 20);

        // valid_in low for 3 cycles before pixel C.
        pix[0] = 32'hA5A5_0001; pix[1] = 32'hA5A5_0002;
        pix[2] = 32'hA5A5_0003; pix[3] = 32'hA5A5_0004;
        run_frame("vgap", -1, 0, 2, 3, -1, 0, 16);
        chk("vgap_w8_to_w9", wcyc[8] - wcyc[7], 1);
        chk("vgap_w9_to_w10", wcyc[9] - wcyc[8], 2);

        // Reset after the 7th write, then a fresh frame.
        pix[0] = 32'hC0DE_0001; pix[1] = 32'hC0DE_0002;
        pix[2] = 32'hC0DE_0003; pix[3] = 32'hC0DE_0004;
        run_frame("rst", -1, 0, -1, 0, -1, 7, -1);
        run_frame("after_rst", -1, 0, -1, 0, -1, 0, 15);

        // valid_in high while IDLE must not be consumed.
        valid_in = 1'b1; data_in = 32'hBAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("idle_ready%0d", k), {31'd0, ready_in}, 32'd0);
            @(negedge clk);
        end
        valid_in = 1'b0;
        pix[0] = 32'h0BAD_F00D; pix[1] = 32'h1234_5678;
        pix[2] = 32'h8765_4321; pix[3] = 32'hFFFF_FFFF;
        run_frame("start_mid", -1, 0, -1, 0, 5, 0, 15);

        // Two frames back to back.
        pix[0] = 32'h0000_0001; pix[1] = 32'h0000_0002;
        pix[2] = 32'h0000_0003; pix[3] = 32'h0000_0004;
        run_frame("b2b_1", -1, 0, -1, 0, -1, 0, 15);
        pix[0] = 32'h8000_0001; pix[1] = 32'h8000_0002;
        pix[2] = 32'h8000_0003; pix[3] = 32'h8000_0004;
        run_frame("b2b_2", -1, 0, -1, 0, -1, 0, 15);

        @(negedge clk);
        chk("end_wrreq", {31'd0, wrreq}, 32'd0);
        chk("end_frame_done", {31'd0, frame_done}, 32'd0);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("end_data_hold", data_out, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
